// File: rtl/systolic_os_feeder.sv
// Operand feeder for an output-stationary systolic array: skews act/wei lanes,
// zero-fills idle slots and sequences clear -> feed -> drain -> done for one tile.
module systolic_os_feeder #(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 16,
  parameter int unsigned X_AXIS  = 3,
  parameter int unsigned Y_AXIS  = 3,
  parameter int unsigned K_MAX   = 16,
  parameter int unsigned PE_LAT  = 1,
  parameter int unsigned WIDTH_K = $clog2(K_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_K-1:0] k_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] in_act [0:Y_AXIS-1],
  input  logic [WIDTH_B-1:0] in_wei [0:X_AXIS-1],
  output logic [WIDTH_A-1:0] act    [0:Y_AXIS-1],
  output logic [WIDTH_B-1:0] wei    [0:X_AXIS-1],
  output logic               reg_clear,
  output logic               busy,
  output logic               done
);

  localparam int unsigned DRAIN_LEN = X_AXIS + Y_AXIS - 1 + PE_LAT;
  localparam int unsigned WIDTH_D   = $clog2(DRAIN_LEN + 1);
  localparam logic [WIDTH_K-1:0] K_LIMIT    = WIDTH_K'(K_MAX);
  localparam logic [WIDTH_D-1:0] DRAIN_LAST = WIDTH_D'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH_K-1:0] k_lat;
  logic [WIDTH_K-1:0] k_cnt;
  logic [WIDTH_D-1:0] drain_cnt;
  logic               accept_c;

  assign accept_c = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = (k_lat != '0) ? FEED : DONE;
      FEED:    if (accept_c && (k_cnt + WIDTH_K'(1) == k_lat)) next_state = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      reg_clear <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (next_state == FEED);
      busy      <= (next_state != IDLE);
      reg_clear <= (next_state == CLEAR);
      done      <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && start) k_lat <= (k_len > K_LIMIT) ? K_LIMIT : k_len;
      if (state == FEED) begin
        if (accept_c) k_cnt <= k_cnt + WIDTH_K'(1);
      end else begin
        k_cnt <= '0;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + WIDTH_D'(1);
      else                drain_cnt <= '0;
    end
  end

  // Lane i holds i+1 stages; stage 0 takes zero whenever nothing is accepted.
  for (genvar gi = 0; gi < int'(Y_AXIS); gi++) begin : g_act
    logic [WIDTH_A-1:0] sr [0:gi];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept_c ? in_act[gi] : '0;
        for (int s = 1; s <= gi; s++) sr[s] <= sr[s-1];
      end
    end
    assign act[gi] = sr[gi];
  end

  for (genvar gj = 0; gj < int'(X_AXIS); gj++) begin : g_wei
    logic [WIDTH_B-1:0] sr [0:gj];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gj; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept_c ? in_wei[gj] : '0;
        for (int s = 1; s <= gj; s++) sr[s] <= sr[s-1];
      end
    end
    assign wei[gj] = sr[gj];
  end

endmodule

// File: tb/tb_systolic_os_feeder.sv
// Bench for systolic_os_feeder: per-cycle lane model driven by observed handshakes,
// tile timing from accept edges, and a behavioural 3x3 output-stationary array.
module tb_systolic_os_feeder;

  localparam int WA = 16;
  localparam int WB = 16;
  localparam int XA = 3;
  localparam int YA = 3;
  localparam int KM = 16;
  localparam int PL = 1;
  localparam int WK = 5;
  localparam int D  = XA + YA - 1 + PL;
  localparam int HN = 4096;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WK-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] in_act [0:YA-1];
  logic [WB-1:0] in_wei [0:XA-1];
  logic [WA-1:0] act    [0:YA-1];
  logic [WB-1:0] wei    [0:XA-1];
  logic          reg_clear;
  logic          busy;
  logic          done;

  systolic_os_feeder #(
    .WIDTH_A(WA), .WIDTH_B(WB), .X_AXIS(XA), .Y_AXIS(YA), .K_MAX(KM), .PE_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wei(in_wei),
    .act(act), .wei(wei), .reg_clear(reg_clear), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int base = 0;
  int naccept = 0;

  // h_*: vector accepted at edge e (zero if none); o_*: DUT outputs after edge e
  logic [WA-1:0] h_act [0:HN-1][0:YA-1];
  logic [WB-1:0] h_wei [0:HN-1][0:XA-1];
  logic [WA-1:0] o_act [0:HN-1][0:YA-1];
  logic [WB-1:0] o_wei [0:HN-1][0:XA-1];
  logic [63:0]   macc  [0:YA-1][0:XA-1];

  int mat_a [0:2][0:2] = '{'{3, 2, 1}, '{6, 5, 4}, '{9, 8, 7}};
  int mat_b [0:2][0:2] = '{'{7, 4, 1}, '{8, 5, 2}, '{9, 6, 3}};
  int mat_c [0:2][0:2] = '{'{46, 28, 10}, '{118, 73, 28}, '{190, 118, 46}};

  typedef struct {
    int          kl;
    logic [31:0] gaps;
    bit          glitch;
    bit          mat;
    int          exp_acc;
  } tile_t;

  tile_t tbl [0:7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, n);
    end
  endtask

  task automatic record_outputs();
    for (int i = 0; i < YA; i++) o_act[n][i] = act[i];
    for (int j = 0; j < XA; j++) o_wei[n][j] = wei[j];
  endtask

  task automatic rand_data();
    for (int i = 0; i < YA; i++) in_act[i] = WA'($urandom);
    for (int j = 0; j < XA; j++) in_wei[j] = WB'($urandom);
  endtask

  // One clock: log the handshake, advance the array model, then check every lane.
  task automatic step();
    logic hs;
    logic [63:0] a;
    logic [63:0] b;
    hs = in_valid && in_ready;
    for (int i = 0; i < YA; i++) h_act[n+1][i] = hs ? in_act[i] : '0;
    for (int j = 0; j < XA; j++) h_wei[n+1][j] = hs ? in_wei[j] : '0;
    if (hs) naccept++;
    for (int i = 0; i < YA; i++)
      for (int j = 0; j < XA; j++) begin
        a = (n >= j) ? 64'(o_act[n-j][i]) : 64'd0;
        b = (n >= i) ? 64'(o_wei[n-i][j]) : 64'd0;
        if (reg_clear) macc[i][j] = '0;
        else           macc[i][j] = macc[i][j] + a * b;
      end
    @(posedge clk);
    #1;
    n++;
    record_outputs();
    for (int i = 0; i < YA; i++)
      chk("act_lane", act[i], (n - i > base) ? 64'(h_act[n-i][i]) : 64'd0);
    for (int j = 0; j < XA; j++)
      chk("wei_lane", wei[j], (n - j > base) ? 64'(h_wei[n-j][j]) : 64'd0);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy !== 1'b0 && b < 64) begin
      step();
      b++;
    end
    if (b >= 64) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, b);
    end
  endtask

  task automatic run_tile(input int kl, input logic [31:0] gaps, input bit glitch,
                          input bit mat, input int exp_acc);
    int eff, s, l, fc, na0, acc_now, exp_done, g;
    wait_idle();
    na0 = naccept;
    eff = (kl > KM) ? KM : kl;
    start = 1'b1;
    k_len = WK'(kl);
    in_valid = 1'b0;
    step();
    start = 1'b0;
    s = n;
    l = s;
    chk("clear_pulse", reg_clear, 1);
    chk("busy_clear", busy, 1);
    chk("ready_clear", in_ready, 0);
    in_valid = 1'($urandom_range(0, 1));
    rand_data();
    step();
    fc = 0;
    acc_now = 0;
    while (eff > 0 && acc_now < eff && fc < 200) begin
      chk("ready_feed", in_ready, 1);
      in_valid = ((gaps >> (fc % 32)) & 32'd1) == 32'd0;
      rand_data();
      if (mat)
        for (int i = 0; i < 3; i++) begin
          in_act[i] = WA'(mat_a[i][acc_now % 3]);
          in_wei[i] = WB'(mat_b[acc_now % 3][i]);
        end
      k_len = WK'($urandom);
      start = glitch && (fc == 1);
      step();
      start = 1'b0;
      if (naccept - na0 != acc_now) l = n;
      acc_now = naccept - na0;
      fc++;
    end
    if (fc >= 200) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: accepted %0d of %0d", acc_now, eff);
    end
    exp_done = (eff == 0) ? s + 1 : l + D;
    g = 0;
    while (n < exp_done && g < 64) begin
      chk("ready_drain", in_ready, 0);
      chk("busy_drain", busy, 1);
      chk("done_early", done, 0);
      chk("clear_extra", reg_clear, 0);
      in_valid = 1'($urandom_range(0, 1));
      rand_data();
      step();
      g++;
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("ready_done", in_ready, 0);
    if (mat)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) chk("mac_out", macc[i][j], 64'(mat_c[i][j]));
    start = glitch;
    k_len = WK'($urandom);
    in_valid = 1'b0;
    step();
    start = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("clear_ignored", reg_clear, 0);
    step();
    chk("busy_idle2", busy, 0);
    chk("clear_ignored2", reg_clear, 0);
    chk("accept_count", 64'(naccept - na0), 64'(exp_acc));
  endtask

  task automatic set_vec(input int a0, input int a1, input int w0, input int w1);
    in_act[0] = WA'(a0); in_act[1] = WA'(a1); in_act[2] = '0;
    in_wei[0] = WB'(w0); in_wei[1] = WB'(w1); in_wei[2] = '0;
  endtask

  task automatic skew_test(input bit bubble);
    int t, g;
    wait_idle();
    start = 1'b1;
    k_len = WK'(2);
    in_valid = 1'b0;
    step();
    start = 1'b0;
    step();
    set_vec(1, 3, 5, 6);
    in_valid = 1'b1;
    step();
    chk("skew_a0_v0", act[0], 1); chk("skew_a1_v0", act[1], 0);
    chk("skew_w0_v0", wei[0], 5); chk("skew_w1_v0", wei[1], 0);
    if (bubble) begin
      in_valid = 1'b0;
      step();
      chk("bub_ready", in_ready, 1);
      chk("bub_a0", act[0], 0); chk("bub_a1", act[1], 3);
      chk("bub_w0", wei[0], 0); chk("bub_w1", wei[1], 6);
    end
    set_vec(2, 4, 7, 8);
    in_valid = 1'b1;
    step();
    t = n;
    chk("skew_a0_v1", act[0], 2); chk("skew_a1_v1", act[1], bubble ? 0 : 3);
    chk("skew_w0_v1", wei[0], 7); chk("skew_w1_v1", wei[1], bubble ? 0 : 6);
    in_valid = 1'b0;
    step();
    chk("skew_drain_ready", in_ready, 0);
    chk("skew_a0_z", act[0], 0); chk("skew_a1_v1b", act[1], 4);
    chk("skew_w0_z", wei[0], 0); chk("skew_w1_v1b", wei[1], 8);
    g = 0;
    while (done !== 1'b1 && g < 40) begin
      step();
      g++;
    end
    chk("skew_done_edge", 64'(n), 64'(t + D));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    rand_data();
    for (int i = 0; i < YA; i++)
      for (int j = 0; j < XA; j++) macc[i][j] = '0;
    tbl[0] = '{3,  32'h0, 1'b0, 1'b1, 3};
    tbl[1] = '{3,  32'h0, 1'b0, 1'b1, 3};
    tbl[2] = '{0,  32'h0, 1'b1, 1'b0, 0};
    tbl[3] = '{20, 32'h0, 1'b0, 1'b0, 16};
    tbl[4] = '{16, 32'h5, 1'b1, 1'b0, 16};
    tbl[5] = '{1,  32'h3, 1'b1, 1'b0, 1};
    tbl[6] = '{5,  32'h2, 1'b0, 1'b0, 5};
    tbl[7] = '{3,  32'h0, 1'b1, 1'b1, 3};

    repeat (3) @(posedge clk);
    #1;
    record_outputs();
    for (int i = 0; i < YA; i++) chk("rst_act", act[i], 0);
    for (int j = 0; j < XA; j++) chk("rst_wei", wei[j], 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", reg_clear, 0);
    rst_n = 1'b1;

    skew_test(1'b0);
    skew_test(1'b1);

    for (int e = 0; e < 8; e++)
      run_tile(tbl[e].kl, tbl[e].gaps, tbl[e].glitch, tbl[e].mat, tbl[e].exp_acc);

    // Abort mid-feed with an asynchronous reset, then restart cleanly.
    wait_idle();
    start = 1'b1;
    k_len = WK'(5);
    step();
    start = 1'b0;
    step();
    in_valid = 1'b1;
    rand_data();
    step();
    rand_data();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < YA; i++) chk("abort_act", act[i], 0);
    for (int j = 0; j < XA; j++) chk("abort_wei", wei[j], 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_clear", reg_clear, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n++;
    record_outputs();
    rst_n = 1'b1;
    base = n;
    run_tile(3, 32'h0, 1'b0, 1'b1, 3);

    for (int r = 0; r < 20; r++) begin
      int kl;
      kl = $urandom_range(0, 20);
      run_tile(kl, $urandom & $urandom, 1'($urandom_range(0, 1)), 1'b0, (kl > KM) ? KM : kl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
